// File: rtl/dual_port_ram_arb.sv
// True dual-port synchronous RAM with same-address write arbitration, write echo and 1/2-cycle reads.
// Optional saturating collision counter enabled by defining DUAL_PORT_RAM_ARB_COLL_CNT_EN.
module dual_port_ram_arb #(
    parameter int DATA_WIDTH    = 7,
    parameter int ADDR_WIDTH    = 12,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_FIRST   = 0,
    parameter int PRIORITY_PORT = 0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_0,
    input  logic                  en_1,
    input  logic                  we_0,
    input  logic                  we_1,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  rvalid_0,
    output logic                  rvalid_1,
    output logic                  coll
`ifdef DUAL_PORT_RAM_ARB_COLL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  coll_cnt
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam bit WIN   = (PRIORITY_PORT != 0);
    localparam bit ECHO  = (WRITE_FIRST != 0);

    logic                  en_arr     [2];
    logic                  we_arr     [2];
    logic [ADDR_WIDTH-1:0] addr_arr   [2];
    logic [DATA_WIDTH-1:0] wdata_arr  [2];
    logic                  commit_arr [2];
    logic [DATA_WIDTH-1:0] commit_data[2];
    logic                  rvalid_arr [2];
    logic [DATA_WIDTH-1:0] rdata_arr  [2];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic coll_now;
    logic coll_reg;

    assign en_arr[0]    = en_0;
    assign en_arr[1]    = en_1;
    assign we_arr[0]    = we_0;
    assign we_arr[1]    = we_1;
    assign addr_arr[0]  = addr_0;
    assign addr_arr[1]  = addr_1;
    assign wdata_arr[0] = wdata_0;
    assign wdata_arr[1] = wdata_1;

    assign coll_now = en_0 & we_0 & en_1 & we_1 & (addr_0 == addr_1);

    // The losing port of a collision drops its write; its echo reports the winner's word.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_arb
            localparam bit SELF = (gi != 0);
            assign commit_arr[gi]  = en_arr[gi] & we_arr[gi] & ~(coll_now && (WIN != SELF));
            assign commit_data[gi] = (coll_now && (WIN != SELF)) ? wdata_arr[WIN] : wdata_arr[gi];
        end
    endgenerate

    // Array has no reset so it maps onto block RAM; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (commit_arr[0]) mem[addr_arr[0]] <= wdata_arr[0];
            if (commit_arr[1]) mem[addr_arr[1]] <= wdata_arr[1];
        end
    end

    generate
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_port
            logic                  s1_valid_reg;
            logic [DATA_WIDTH-1:0] s1_data_reg;

            // Cross-port reads see the pre-write word because the array read is non-blocking.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid_reg <= 1'b0;
                    s1_data_reg  <= '0;
                end else begin
                    s1_valid_reg <= en_arr[gi] & (~we_arr[gi] | ECHO);
                    if (en_arr[gi] && !we_arr[gi])
                        s1_data_reg <= mem[addr_arr[gi]];
                    else if (en_arr[gi] && we_arr[gi] && ECHO)
                        s1_data_reg <= commit_data[gi];
                    else
                        s1_data_reg <= '0;
                end
            end

            if (READ_LATENCY >= 2) begin : g_lat2
                logic                  s2_valid_reg;
                logic [DATA_WIDTH-1:0] s2_data_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        s2_valid_reg <= 1'b0;
                        s2_data_reg  <= '0;
                    end else begin
                        s2_valid_reg <= s1_valid_reg;
                        s2_data_reg  <= s1_data_reg;
                    end
                end

                assign rvalid_arr[gi] = s2_valid_reg;
                assign rdata_arr[gi]  = s2_data_reg;
            end else begin : g_lat1
                assign rvalid_arr[gi] = s1_valid_reg;
                assign rdata_arr[gi]  = s1_data_reg;
            end
        end
    endgenerate

    assign rvalid_0 = rvalid_arr[0];
    assign rvalid_1 = rvalid_arr[1];
    assign rdata_0  = rdata_arr[0];
    assign rdata_1  = rdata_arr[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coll_reg <= 1'b0;
        else        coll_reg <= coll_now;
    end

    assign coll = coll_reg;

`ifdef DUAL_PORT_RAM_ARB_COLL_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_reg;

    // Counts in the same edge that raises coll, so coll_cnt already includes the visible pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_reg <= '0;
        else if (coll_now && (cnt_reg != {CNT_WIDTH{1'b1}}))
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign coll_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_dual_port_ram_arb.sv
// Scoreboard bench for dual_port_ram_arb: two instances (A: lat 2, write-first, port 1 priority, 2-bit
// counter; B: defaults) share the same directed stimulus; a negedge monitor pops expected results.
module tb_dual_port_ram_arb;

    localparam int DW = 7;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          en0, we0, en1, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    logic [DW-1:0] rd_a0, rd_a1, rd_b0, rd_b1;
    logic          rv_a0, rv_a1, rv_b0, rv_b1;
    logic          coll_a, coll_b;
`ifdef DUAL_PORT_RAM_ARB_COLL_CNT_EN
    logic [1:0]    cnt_a;
    logic [15:0]   cnt_b;
    int            cnt_s [2];
    assign cnt_s[0] = {30'd0, cnt_a};
    assign cnt_s[1] = {16'd0, cnt_b};
`endif

    dual_port_ram_arb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
        .WRITE_FIRST(1), .PRIORITY_PORT(1), .CNT_WIDTH(2)
    ) u_a (
        .clk(clk), .rst_n(rst_n),
        .en_0(en0), .en_1(en1), .we_0(we0), .we_1(we1),
        .addr_0(a0), .addr_1(a1), .wdata_0(d0), .wdata_1(d1),
        .rdata_0(rd_a0), .rdata_1(rd_a1), .rvalid_0(rv_a0), .rvalid_1(rv_a1),
        .coll(coll_a)
`ifdef DUAL_PORT_RAM_ARB_COLL_CNT_EN
        , .coll_cnt(cnt_a)
`endif
    );

    dual_port_ram_arb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
        .WRITE_FIRST(0), .PRIORITY_PORT(0), .CNT_WIDTH(16)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .en_0(en0), .en_1(en1), .we_0(we0), .we_1(we1),
        .addr_0(a0), .addr_1(a1), .wdata_0(d0), .wdata_1(d1),
        .rdata_0(rd_b0), .rdata_1(rd_b1), .rvalid_0(rv_b0), .rvalid_1(rv_b1),
        .coll(coll_b)
`ifdef DUAL_PORT_RAM_ARB_COLL_CNT_EN
        , .coll_cnt(cnt_b)
`endif
    );

    // Index i = instance*2 + port.
    logic          rv [4];
    logic [DW-1:0] rd [4];
    logic          coll_s [2];
    assign rv[0] = rv_a0; assign rv[1] = rv_a1; assign rv[2] = rv_b0; assign rv[3] = rv_b1;
    assign rd[0] = rd_a0; assign rd[1] = rd_a1; assign rd[2] = rd_b0; assign rd[3] = rd_b1;
    assign coll_s[0] = coll_a;
    assign coll_s[1] = coll_b;

    int lat_p [2] = '{2, 1};
    int wf_p  [2] = '{1, 0};
    int pr_p  [2] = '{1, 0};
    int cmax  [2] = '{3, 65535};

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          rq [4][$];
    int            cq [2][$];
    logic [DW-1:0] mem_m [2][4096];
    int            cnt_m [2];
    int            checks = 0;
    int            fails  = 0;
    int            cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // One request cycle on both ports; expected responses go into the scoreboard.
    task automatic apply(input logic e0, input logic w0, input logic [AW-1:0] ad0, input logic [DW-1:0] wd0,
                         input logic e1, input logic w1, input logic [AW-1:0] ad1, input logic [DW-1:0] wd1);
        logic          e  [2];
        logic          w  [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        logic          cl;
        exp_t          item;
        @(posedge clk);
        #1;
        en0 = e0; we0 = w0; a0 = ad0; d0 = wd0;
        en1 = e1; we1 = w1; a1 = ad1; d1 = wd1;
        e[0] = e0; w[0] = w0; ad[0] = ad0; wd[0] = wd0;
        e[1] = e1; w[1] = w1; ad[1] = ad1; wd[1] = wd1;
        cl = e0 & w0 & e1 & w1 & (ad0 == ad1);
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                item.due = cyc + lat_p[k];
                if (e[p] && !w[p]) begin
                    item.data = mem_m[k][ad[p]];
                    rq[k*2+p].push_back(item);
                end else if (e[p] && w[p] && wf_p[k] != 0) begin
                    item.data = (cl && p != pr_p[k]) ? wd[pr_p[k]] : wd[p];
                    rq[k*2+p].push_back(item);
                end
            end
            for (int p = 0; p < 2; p++)
                if (e[p] && w[p] && !(cl && p != pr_p[k])) mem_m[k][ad[p]] = wd[p];
            if (cl) cq[k].push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) apply(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        en0 = 0; we0 = 0; a0 = '0; d0 = '0;
        en1 = 0; we1 = 0; a1 = '0; d1 = '0;
        for (int i = 0; i < 4; i++) rq[i].delete();
        for (int k = 0; k < 2; k++) begin
            cq[k].delete();
            cnt_m[k] = 0;
        end
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic ex;
        for (int i = 0; i < 4; i++) begin
            if (rv[i]) begin
                checks++;
                if (rq[i].size() == 0) begin
                    fails++;
                    $display("FAIL rvalid_unexpected inst%0d port%0d cyc=%0d: got rvalid=1 rdata=%h, required rvalid=0",
                             i / 2, i % 2, cyc, rd[i]);
                end else begin
                    e = rq[i].pop_front();
                    if (e.due != cyc || rd[i] !== e.data) begin
                        fails++;
                        $display("FAIL read_data inst%0d port%0d: got rvalid@%0d rdata=%h, required rvalid@%0d rdata=%h",
                                 i / 2, i % 2, cyc, rd[i], e.due, e.data);
                    end
                end
            end else begin
                checks++;
                if (rd[i] !== '0) begin
                    fails++;
                    $display("FAIL idle_rdata inst%0d port%0d cyc=%0d: got rdata=%h, required 0", i / 2, i % 2, cyc, rd[i]);
                end
                if (rq[i].size() > 0) begin
                    checks++;
                    if (rq[i][0].due <= cyc) begin
                        fails++;
                        $display("FAIL rvalid_missing inst%0d port%0d cyc=%0d: got rvalid=0, required rvalid=1 rdata=%h",
                                 i / 2, i % 2, cyc, rq[i][0].data);
                        void'(rq[i].pop_front());
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            ex = (cq[k].size() > 0 && cq[k][0] == cyc);
            if (ex) void'(cq[k].pop_front());
            checks++;
            if (coll_s[k] !== ex) begin
                fails++;
                $display("FAIL coll inst%0d cyc=%0d: got %b, required %b", k, cyc, coll_s[k], ex);
            end
`ifdef DUAL_PORT_RAM_ARB_COLL_CNT_EN
            if (ex && cnt_m[k] < cmax[k]) cnt_m[k]++;
            checks++;
            if (cnt_s[k] != cnt_m[k]) begin
                fails++;
                $display("FAIL coll_cnt inst%0d cyc=%0d: got %0d, required %0d", k, cyc, cnt_s[k], cnt_m[k]);
            end
`endif
        end
    end

    initial begin
        en0 = 0; we0 = 0; a0 = '0; d0 = '0;
        en1 = 0; we1 = 0; a1 = '0; d1 = '0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        apply(1, 1, 12'h010, 7'h55, 0, 0, 12'h000, 7'h00);   // write 0x010 <- 55
        apply(0, 0, 12'h000, 7'h00, 1, 0, 12'h010, 7'h00);   // port 1 reads 55
        apply(1, 1, 12'h001, 7'h11, 1, 1, 12'hFFF, 7'h22);   // dual write, no collision
        apply(1, 0, 12'h001, 7'h00, 1, 0, 12'hFFF, 7'h00);
        apply(1, 1, 12'h100, 7'h0A, 1, 1, 12'h100, 7'h0B);   // collision
        apply(1, 0, 12'h100, 7'h00, 1, 0, 12'h100, 7'h00);
        apply(1, 1, 12'h020, 7'h03, 0, 0, 12'h000, 7'h00);
        apply(1, 1, 12'h020, 7'h7F, 1, 0, 12'h020, 7'h00);   // cross-port: reader gets 03
        apply(0, 0, 12'h000, 7'h00, 1, 0, 12'h020, 7'h00);   // now 7F
        for (int i = 0; i < 4; i++)                          // four more collisions (saturation)
            apply(1, 1, 12'(12'h200 + i), 7'(7'h30 + i), 1, 1, 12'(12'h200 + i), 7'(7'h40 + i));
        apply(1, 0, 12'h001, 7'h00, 1, 0, 12'h203, 7'h00);   // back-to-back reads
        apply(1, 0, 12'h100, 7'h00, 1, 0, 12'h200, 7'h00);
        apply(1, 0, 12'h020, 7'h00, 1, 0, 12'hFFF, 7'h00);
        apply(1, 0, 12'h010, 7'h00, 0, 0, 12'h000, 7'h00);
        idle(3);

        apply(1, 0, 12'h100, 7'h00, 1, 0, 12'h010, 7'h00);   // read then reset mid-flight
        do_reset(2);
        apply(1, 0, 12'h100, 7'h00, 1, 0, 12'h010, 7'h00);   // contents survive reset
        apply(1, 0, 12'h020, 7'h00, 0, 0, 12'h000, 7'h00);
        idle(5);

        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rq[i].size() != 0) begin
                fails++;
                $display("FAIL leftover inst%0d port%0d: got %0d pending results, required 0", i / 2, i % 2, rq[i].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus by 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dual_port_ram_arb.md
# dual_port_ram_arb

Parametrised true dual-port synchronous RAM that succeeds the fixed 7-bit × 4096 single-write-per-cycle dual-port RAM. It replaces the tri-state buses with separate write and read data ports per channel. Both ports may write in the same cycle, with deterministic same-address collision arbitration, a selectable read-during-write mode and a selectable 1- or 2-cycle read latency with valid strobes. It sits between the display/character-generation logic and any producer that updates the frame/text buffer concurrently.

## Interface
- DATA_WIDTH, 7: word width in bits.
- ADDR_WIDTH, 12: address width; depth = 2**ADDR_WIDTH words.
- READ_LATENCY, 1: 1 or 2 cycles from read request to rdata/rvalid; any other value is illegal.
- WRITE_FIRST, 0: 0 = same-port read returns the old word; 1 = returns the word committed this cycle.
- PRIORITY_PORT, 0: port whose write wins a same-address write-write collision.
- CNT_WIDTH, 16: width of the collision counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_0 / en_1  in  1  port access enable.
- we_0 / we_1  in  1  write when 1, read when 0; qualified by en.
- addr_0 / addr_1  in  ADDR_WIDTH  word address.
- wdata_0 / wdata_1  in  DATA_WIDTH  write data.
- rdata_0 / rdata_1  out  DATA_WIDTH  read data; 0 when rvalid is 0.
- rvalid_0 / rvalid_1  out  1  one-cycle strobe marking valid rdata.
- coll  out  1  one-cycle pulse on a same-address write-write collision.
- coll_cnt  out  CNT_WIDTH  saturating collision count (exists only with the macro).

## Operation
- Write: an access with en_x=1 and we_x=1 stores wdata_x at addr_x on the rising edge of clk.
- Dual write, different addresses: both writes commit in the same cycle.
- Dual write, same address: only the PRIORITY_PORT write commits. The other write is dropped and coll pulses for one cycle.
- Read: an access with en_x=1 and we_x=0 returns mem[addr_x] after READ_LATENCY cycles, together with rvalid_x=1.
- Idle or write cycle on a port: that port's pipeline carries rvalid=0 and rdata=0.
- Cross-port read/write to the same address in the same cycle: the reading port always gets the old word, independent of WRITE_FIRST.
- Same-port read-during-write cannot occur (we selects one operation). WRITE_FIRST applies only to the write-echo path:
  - WRITE_FIRST=1: a write also produces rvalid_x=1 after READ_LATENCY cycles, with rdata_x = the word actually committed at addr_x. If the port lost arbitration, that is the winner's data.
  - WRITE_FIRST=0: a write produces no rvalid.
- Memory contents are not reset and have no defined power-up value.
- While rst_n=0, all writes are ignored.

## Timing
- Reset values: rdata_0/1=0, rvalid_0/1=0, coll=0, coll_cnt=0. All pipeline stages are cleared.
- Reset asserted mid-operation: in-flight reads are discarded and their rvalid never appears. Memory keeps its contents.
- READ_LATENCY=1: request at edge N gives rdata/rvalid valid after edge N+1 (one register stage: the array read).
- READ_LATENCY=2: an extra output register adds one cycle. Back-to-back requests give one result per cycle with no bubbles.
- coll is registered: a collision sampled at edge N drives coll high for the cycle after edge N.
- No stall or back-pressure exists; every accepted request completes.

## Configuration
- Macro: DUAL_PORT_RAM_ARB_COLL_CNT_EN.
- Defined:
  - coll_cnt is present and increments by 1 on every coll pulse.
  - It saturates at 2**CNT_WIDTH-1 and does not wrap.
  - It clears only on reset.
- Undefined: the coll_cnt port and counter logic are absent. coll still operates.

## Test plan
- Reset then read: write 7'h55 to address 0x010 via port 0, then read it via port 1. rvalid_1 is high exactly READ_LATENCY cycles after the request and rdata_1=7'h55. During reset, rdata_1 and rvalid_1 are 0.
- Dual write, different addresses: port 0 writes 0x001←7'h11 and port 1 writes 0xFFF←7'h22 in the same cycle. A later readback returns both values and coll stays 0.
- Dual write, same address, PRIORITY_PORT=1: port 0 writes 7'h0A and port 1 writes 7'h0B to 0x100. Memory holds 7'h0B, coll pulses one cycle and coll_cnt=1. With WRITE_FIRST=1, the port 0 echo returns 7'h0B.
- Cross-port read/write: 0x020 holds 7'h03; port 1 reads 0x020 while port 0 writes 7'h7F there. rdata_1=7'h03, and the next read returns 7'h7F.
- Counter saturation, CNT_WIDTH=2: drive 5 collisions. coll_cnt sequence is 1, 2, 3, 3, 3.
- Reset mid-read, READ_LATENCY=2: assert rst_n=0 one cycle after a read request. No rvalid appears, and memory still reads back its previous contents after reset.
